mvm_sequencer: RTL and testbench
================================

Name: mvm_sequencer

Overview:
- Controller for the Minilab1 8x8 matrix-vector multiply datapath.
- On a start pulse it fetches 8 matrix rows plus 1 vector row from the on-chip memory through an Avalon-MM style read port.
- It unpacks each 64-bit word into bytes and writes them into the 9 per-row input FIFOs.
- It then clears the MAC array and streams the FIFOs into it in lockstep, then signals done. It sits between the memory wrapper and the FIFO/MAC array in the Minilab1 top level.

Parameters:
- ROWS, 8, number of matrix rows and MAC units; FIFO ROWS is the vector FIFO.
- COLS, 8, bytes per row and MAC accumulation length.
- DATA_W, 8, element width.
- MEM_W, 64, memory word width; must equal COLS*DATA_W.
- ADDR_W, 32, memory address width.
- BASE_ADDR, 0, word address of matrix row 0; the vector sits at BASE_ADDR+ROWS.

Ports:
- clk  input  1  system clock (CLOCK_50 domain).
- rst_n  input  1  synchronous active-low reset (driven from KEY[0]).
- start  input  1  single-cycle request to run one multiply.
- mem_address  output  ADDR_W  word address of the current row.
- mem_read  output  1  read request.
- mem_readdata  input  MEM_W  returned row word.
- mem_readdatavalid  input  1  mem_readdata valid this cycle.
- mem_waitrequest  input  1  memory stall; the request is held while this is high.
- fifo_wr_en  output  ROWS+1  one-hot FIFO write strobe.
- fifo_wr_data  output  DATA_W  byte broadcast to all FIFOs.
- fifo_rd_en  output  1  lockstep read strobe to all FIFOs.
- mac_clr  output  1  one-cycle accumulator clear.
- mac_en  output  1  MAC accumulate enable; aligned to FIFO read data (1-cycle FIFO read latency).
- busy  output  1  high in every state except IDLE.
- done  output  1  one-cycle completion pulse.

Behaviour:
- Clock and reset: a single clock clk. rst_n is synchronous and active-low, sampled on the rising edge of clk.
- Reset values: state IDLE, row=0, idx=0. All outputs are 0, mem_address is BASE_ADDR, and the internal word register is 0.
- Reset mid-operation returns to IDLE on the next edge with all strobes low. FIFO contents are not touched; the next run's mac_clr handles the accumulators.

States and transitions:
- IDLE: start=1 -> REQ with row=0. start is ignored in all other states.
- REQ: mem_read=1 and mem_address=BASE_ADDR+row. The request is held stable while mem_waitrequest=1. The edge with mem_waitrequest=0 -> WAIT.
- WAIT: mem_read=0. When mem_readdatavalid=1, latch mem_readdata -> UNPACK with idx=0.
  - mem_readdatavalid outside WAIT is ignored.
  - There is no timeout.
- UNPACK: COLS cycles. fifo_wr_en = one-hot(row) and fifo_wr_data = byte idx of the latched word.
  - Byte 0 is bits [DATA_W-1:0] and is written first.
  - At idx=COLS-1: if row==ROWS -> CLR, else row+1 -> REQ.
- CLR: mac_clr=1 for one cycle -> COMPUTE with idx=0.
- COMPUTE: fifo_rd_en=1 for COLS cycles. mac_en is fifo_rd_en registered by one cycle, so mac_en spans COMPUTE cycles 2..COLS plus DRAIN.
- DRAIN: one cycle; the final mac_en=1 -> DONE.
- DONE: done=1 for one cycle, busy still 1 -> IDLE.

Width and counter rules:
- row is a $clog2(ROWS+1)-bit counter and idx a $clog2(COLS)-bit counter; neither wraps beyond its terminal value.
- mem_address = BASE_ADDR + row, zero-extended.

Latency:
- Zero-waitrequest memory with readdatavalid one cycle after acceptance: 10 cycles per row.
- done is high in cycle 101 after the edge sampling start (9x10 fetch + CLR 1 + COMPUTE 8 + DRAIN 1 + DONE 1).

Invariants:
- fifo_wr_en is never active in the same cycle as fifo_rd_en.
- At most one fifo_wr_en bit is high at a time.

Decomposition:
- mvm_pkg holds:
  - the state enum (IDLE, REQ, WAIT, UNPACK, CLR, COMPUTE, DRAIN, DONE);
  - the ROWS/COLS/DATA_W default constants;
  - a localparam for the vector FIFO index (ROWS).
- One natural sub-module: word_unpacker, which holds the latched MEM_W word, a byte-select counter and the last-byte flag.
- The FSM stays in mvm_sequencer.

Test Plan:
- Reset, then a start pulse with a 1-cycle-latency memory model holding row r = bytes {r*8+7..r*8} -> fifo_wr_en steps through 0x001..0x100, 8 writes each, with data 0,1,2..71 in order; done is high exactly 101 cycles after start.
- Waitrequest stalls: hold mem_waitrequest=1 for 3 cycles on row 4 -> mem_read and mem_address=4 stay stable throughout; the total run takes +3 cycles (done at cycle 104); the byte sequence is unchanged.
- Compute window: check that mac_clr pulses once, fifo_rd_en is high for exactly 8 consecutive cycles, and mac_en is high for exactly 8 cycles lagging fifo_rd_en by 1. With all-ones data the MAC model accumulates 8 per row.
- start while busy: pulse start during row 2 UNPACK and again during COMPUTE -> no restart, one done pulse, and the row sequence is unchanged.
- rst_n=0 for one cycle during row 5 WAIT -> next cycle state is IDLE, all outputs 0 and busy=0; a subsequent start completes a full run with done at cycle 101.
- Spurious mem_readdatavalid in IDLE and in UNPACK -> no FIFO writes and no state change.

Source files
------------

// File: rtl/mvm_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mvm_pkg : shared state encoding and default sizes for the MVM sequencer
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
package mvm_pkg;

    localparam int c_DEF_ROWS   = 8;
    localparam int c_DEF_COLS   = 8;
    localparam int c_DEF_DATA_W = 8;
    localparam int c_VEC_FIFO   = c_DEF_ROWS;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        UNPACK  = 3'd3,
        CLR     = 3'd4,
        COMPUTE = 3'd5,
        DRAIN   = 3'd6,
        DONE    = 3'd7
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mvm_sequencer_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mvm_sequencer_if : memory read port plus FIFO/MAC control bundle
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
interface mvm_sequencer_if
    import mvm_pkg::*;
#(
    parameter int ROWS   = c_DEF_ROWS,
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int MEM_W  = 64,
    parameter int ADDR_W = 32
);
    logic [ADDR_W-1:0] mem_address;
    logic              mem_read;
    logic [MEM_W-1:0]  mem_readdata;
    logic              mem_readdatavalid;
    logic              mem_waitrequest;
    logic [ROWS:0]     fifo_wr_en;
    logic [DATA_W-1:0] fifo_wr_data;
    logic              fifo_rd_en;
    logic              mac_clr;
    logic              mac_en;

    modport master (
        output mem_address, mem_read, fifo_wr_en, fifo_wr_data,
               fifo_rd_en, mac_clr, mac_en,
        input  mem_readdata, mem_readdatavalid, mem_waitrequest
    );

    modport slave (
        input  mem_address, mem_read, fifo_wr_en, fifo_wr_data,
               fifo_rd_en, mac_clr, mac_en,
        output mem_readdata, mem_readdatavalid, mem_waitrequest
    );
endinterface
`default_nettype wire

// File: rtl/word_unpacker.sv
`default_nettype none
// ---------------------------------------------------------------------------
// word_unpacker : latches one memory word and walks its bytes LSB first
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module word_unpacker
    import mvm_pkg::*;
#(
    parameter int COLS   = c_DEF_COLS,
    parameter int DATA_W = c_DEF_DATA_W,
    parameter int MEM_W  = 64
) (
    input  wire logic              clk,
    input  wire logic              rst_n,
    input  wire logic              load_i,
    input  wire logic [MEM_W-1:0]  word_i,
    input  wire logic              adv_i,
    input  wire logic              clr_i,
    output logic [DATA_W-1:0]      byte_o,
    output logic                   last_o
);
    localparam int c_IDX_W = $clog2(COLS);

    logic [MEM_W-1:0]   word_q;
    logic [c_IDX_W-1:0] idx_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            word_q <= '0;
            idx_q  <= '0;
        end else if (load_i) begin
            word_q <= word_i;
            idx_q  <= '0;
        end else if (clr_i) begin
            idx_q  <= '0;
        end else if (adv_i) begin
            idx_q  <= last_o ? '0 : idx_q + 1'b1;
        end
    end

    assign last_o = (idx_q == c_IDX_W'(COLS - 1));
    assign byte_o = word_q[idx_q*DATA_W +: DATA_W];

endmodule
`default_nettype wire

// File: rtl/mvm_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// mvm_sequencer : fetches matrix/vector rows into FIFOs, then runs the MACs
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module mvm_sequencer
    import mvm_pkg::*;
#(
    parameter int          ROWS      = c_DEF_ROWS,
    parameter int          COLS      = c_DEF_COLS,
    parameter int          DATA_W    = c_DEF_DATA_W,
    parameter int          MEM_W     = 64,
    parameter int          ADDR_W    = 32,
    parameter int unsigned BASE_ADDR = 0
) (
    input  wire logic       clk,
    input  wire logic       rst_n,
    input  wire logic       start,
    output logic            busy,
    output logic            done,
    mvm_sequencer_if.master bus
);
    localparam int c_ROW_W = $clog2(ROWS + 1);

    state_t             state_q, state_d;
    logic [c_ROW_W-1:0] row_q, row_d;
    logic               mac_en_q;

    logic              mem_read;
    logic [ROWS:0]     wr_en;
    logic              rd_en;
    logic              clr;
    logic              load;
    logic              adv;
    logic              clr_idx;
    logic              last;
    logic [DATA_W-1:0] cur_byte;

    word_unpacker #(
        .COLS   (COLS),
        .DATA_W (DATA_W),
        .MEM_W  (MEM_W)
    ) u_unpacker (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (load),
        .word_i (bus.mem_readdata),
        .adv_i  (adv),
        .clr_i  (clr_idx),
        .byte_o (cur_byte),
        .last_o (last)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            row_q    <= '0;
            mac_en_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            mac_en_q <= rd_en;
        end
    end

    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        mem_read = 1'b0;
        wr_en    = '0;
        rd_en    = 1'b0;
        clr      = 1'b0;
        load     = 1'b0;
        adv      = 1'b0;
        clr_idx  = 1'b0;
        done     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = REQ;
                    row_d   = '0;
                end
            end
            REQ: begin
                mem_read = 1'b1;
                if (!bus.mem_waitrequest) state_d = WAIT;
            end
            WAIT: begin
                if (bus.mem_readdatavalid) begin
                    load    = 1'b1;
                    state_d = UNPACK;
                end
            end
            UNPACK: begin
                // Row ROWS is the vector row, landing in the last FIFO.
                wr_en = (ROWS + 1)'(1) << row_q;
                adv   = 1'b1;
                if (last) begin
                    if (row_q == c_ROW_W'(ROWS)) begin
                        state_d = CLR;
                    end else begin
                        row_d   = row_q + 1'b1;
                        state_d = REQ;
                    end
                end
            end
            CLR: begin
                clr     = 1'b1;
                clr_idx = 1'b1;
                state_d = COMPUTE;
            end
            COMPUTE: begin
                rd_en = 1'b1;
                adv   = 1'b1;
                if (last) state_d = DRAIN;
            end
            DRAIN: state_d = DONE;
            DONE: begin
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy             = (state_q != IDLE);
    assign bus.mem_read     = mem_read;
    assign bus.mem_address  = ADDR_W'(BASE_ADDR) + ADDR_W'(row_q);
    assign bus.fifo_wr_en   = wr_en;
    assign bus.fifo_wr_data = (state_q == UNPACK) ? cur_byte : '0;
    assign bus.fifo_rd_en   = rd_en;
    assign bus.mac_clr      = clr;
    assign bus.mac_en       = mac_en_q;

endmodule
`default_nettype wire

// File: tb/tb_mvm_sequencer.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_mvm_sequencer : directed runs against a transaction-level FIFO/MAC model
// Rev 1.0 : initial release
// ---------------------------------------------------------------------------
module tb_mvm_sequencer;
    import mvm_pkg::*;

    localparam int ROWS = 8, COLS = 8, DATA_W = 8, MEM_W = 64, ADDR_W = 32;
    localparam int NWR  = (ROWS + 1) * COLS;

    logic clk = 1'b0, rst_n = 1'b0, start = 1'b0;
    logic busy, done;

    mvm_sequencer_if #(.ROWS(ROWS), .DATA_W(DATA_W), .MEM_W(MEM_W), .ADDR_W(ADDR_W)) bus ();

    mvm_sequencer #(
        .ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .MEM_W(MEM_W),
        .ADDR_W(ADDR_W), .BASE_ADDR(0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .start(start), .busy(busy), .done(done),
        .bus(bus.master)
    );

    always #5 clk = ~clk;

    int total = 0, bad = 0;

    task automatic check(input string nm, input longint unsigned act, input longint unsigned exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // memory model
    logic [MEM_W-1:0] mem_word [0:ROWS];
    int  stall_addr = -1, stall_left = 0;
    bit  spur = 0;

    initial begin
        bit acc, wr;
        int addr;
        bus.mem_waitrequest   = 1'b0;
        bus.mem_readdatavalid = 1'b0;
        bus.mem_readdata      = '0;
        forever begin
            @(negedge clk);
            wr = bus.mem_read && stall_left > 0 && int'(bus.mem_address) == stall_addr;
            if (wr) stall_left--;
            bus.mem_waitrequest = wr;
            acc  = bus.mem_read && !wr && rst_n;
            addr = int'(bus.mem_address);
            @(posedge clk);
            #1;
            if (acc && addr <= ROWS) begin
                bus.mem_readdatavalid = 1'b1;
                bus.mem_readdata      = mem_word[addr];
            end else if (spur) begin
                bus.mem_readdatavalid = 1'b1;
                bus.mem_readdata      = '1;
                spur = 0;
            end else begin
                bus.mem_readdatavalid = 1'b0;
                bus.mem_readdata      = '0;
            end
        end
    end

    // transaction-level model: expected write order, external FIFOs and MACs
    logic [ROWS:0]  q_en [$];
    logic [7:0]     q_dat [$];
    logic [7:0]     fq [0:ROWS][$];
    logic [7:0]     stg [0:ROWS];
    longint         acc_m [0:ROWS-1];
    longint         exp_acc [0:ROWS-1];
    bit  run_active = 0, stg_v = 0, prev_rd = 0;
    int  cyc = 0, exp_lat = 101, done_cnt = 0, done_cyc = 0, wr_seen = 0;
    int  rd_cnt, mac_cnt, clr_cnt, first_rd, last_rd, clr_cyc;

    task automatic load_expectations();
        q_en.delete();
        q_dat.delete();
        for (int r = 0; r <= ROWS; r++)
            for (int j = 0; j < COLS; j++) begin
                q_en.push_back((ROWS + 1)'(1) << r);
                q_dat.push_back(mem_word[r][8*j +: 8]);
            end
        for (int r = 0; r < ROWS; r++) begin
            exp_acc[r] = 0;
            for (int j = 0; j < COLS; j++)
                exp_acc[r] += longint'(mem_word[r][8*j +: 8]) * longint'(mem_word[ROWS][8*j +: 8]);
        end
        rd_cnt = 0; mac_cnt = 0; clr_cnt = 0; first_rd = 0; last_rd = 0;
        clr_cyc = 0; done_cnt = 0;
    endtask

    always @(negedge clk) begin
        if (!rst_n) begin
            prev_rd = 0;
            stg_v   = 0;
        end else begin
            if (run_active) cyc++;
            check("wr_rd_exclusive", 64'((|bus.fifo_wr_en) && bus.fifo_rd_en), 0);
            check("wr_onehot", 64'($countones(bus.fifo_wr_en) <= 1), 1);
            check("mac_en_lag", bus.mac_en, prev_rd);
            if (busy && !run_active) check("busy_outside_run", busy, 0);
            if (bus.mem_read) begin
                if (run_active)
                    check("mem_address", bus.mem_address, (NWR - q_en.size()) / COLS);
                else
                    check("mem_read_idle", bus.mem_read, 0);
            end
            if (|bus.fifo_wr_en) begin
                wr_seen++;
                if (q_en.size() == 0) check("unexpected_write", bus.fifo_wr_en, 0);
                else begin
                    check("wr_en", bus.fifo_wr_en, q_en.pop_front());
                    check("wr_data", bus.fifo_wr_data, q_dat.pop_front());
                end
                for (int r = 0; r <= ROWS; r++)
                    if (bus.fifo_wr_en[r]) fq[r].push_back(bus.fifo_wr_data);
            end
            if (bus.mac_clr) begin
                clr_cnt++;
                clr_cyc = cyc;
                for (int r = 0; r < ROWS; r++) acc_m[r] = 0;
            end
            if (bus.mac_en) begin
                mac_cnt++;
                if (stg_v)
                    for (int r = 0; r < ROWS; r++)
                        acc_m[r] += longint'(stg[r]) * longint'(stg[ROWS]);
            end
            stg_v = 0;
            if (bus.fifo_rd_en) begin
                rd_cnt++;
                if (rd_cnt == 1) first_rd = cyc;
                last_rd = cyc;
                for (int r = 0; r <= ROWS; r++) begin
                    if (fq[r].size() == 0) check("fifo_underflow", 1, 0);
                    else stg[r] = fq[r].pop_front();
                end
                stg_v = 1;
            end
            prev_rd = bus.fifo_rd_en;
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
                if (!run_active) check("done_outside_run", done, 0);
                else begin
                    check("latency", cyc, exp_lat);
                    check("writes_left", q_en.size(), 0);
                    check("rd_cnt", rd_cnt, COLS);
                    check("rd_consecutive", last_rd - first_rd, COLS - 1);
                    check("mac_cnt", mac_cnt, COLS);
                    check("clr_cnt", clr_cnt, 1);
                    check("clr_before_rd", first_rd - clr_cyc, 1);
                    for (int r = 0; r < ROWS; r++)
                        check($sformatf("acc_row%0d", r), acc_m[r], exp_acc[r]);
                end
                run_active = 0;
            end
            if (start && !busy && !run_active) begin
                run_active = 1;
                cyc = 0;
                load_expectations();
            end
        end
    end

    task automatic pulse_start();
        @(posedge clk); #1 start = 1'b1;
        @(posedge clk); #1 start = 1'b0;
    endtask

    task automatic wait_done(input string nm);
        bit seen = 0;
        for (int i = 0; i < 300 && !seen; i++) begin
            @(negedge clk);
            seen = done;
        end
        if (!seen) check({nm, "_timeout"}, 0, 1);
        @(posedge clk); #1;
    endtask

    task automatic wait_wr_row(input int r, output bit ok);
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = bus.fifo_wr_en[r];
        end
        if (!ok) check($sformatf("wait_row%0d_timeout", r), 0, 1);
    endtask

    task automatic fill_mem(input bit ones);
        for (int r = 0; r <= ROWS; r++)
            for (int j = 0; j < COLS; j++)
                mem_word[r][8*j +: 8] = ones ? 8'd1 : 8'(r * 8 + j);
    endtask

    task automatic check_quiet(input string nm);
        check({nm, "_busy"}, busy, 0);
        check({nm, "_done"}, done, 0);
        check({nm, "_mem_read"}, bus.mem_read, 0);
        check({nm, "_mem_address"}, bus.mem_address, 0);
        check({nm, "_wr_en"}, bus.fifo_wr_en, 0);
        check({nm, "_wr_data"}, bus.fifo_wr_data, 0);
        check({nm, "_rd_en"}, bus.fifo_rd_en, 0);
        check({nm, "_mac_clr"}, bus.mac_clr, 0);
        check({nm, "_mac_en"}, bus.mac_en, 0);
    endtask

    initial begin
        bit ok;
        int w0;
        fill_mem(0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_quiet("reset");

        // nominal run, with literal pins on the model
        exp_lat = 101;
        pulse_start();
        wait_done("run1");
        check("run1_done_cycle", done_cyc, 101);
        check("run1_acc0_literal", acc_m[0], 1932);
        check("run1_acc7_literal", acc_m[7], 32172);

        // waitrequest stall on row 4
        stall_addr = 4; stall_left = 3; exp_lat = 104;
        pulse_start();
        wait_done("run2");
        check("run2_done_cycle", done_cyc, 104);
        check("run2_stall_used", stall_left, 0);
        stall_addr = -1;

        // all-ones data
        fill_mem(1); exp_lat = 101;
        pulse_start();
        wait_done("run3");
        for (int r = 0; r < ROWS; r++)
            check($sformatf("run3_ones_acc%0d", r), acc_m[r], 8);

        // start while busy, spurious readdatavalid during UNPACK
        fill_mem(0);
        pulse_start();
        wait_wr_row(2, ok);
        start = 1'b1; @(posedge clk); #1 start = 1'b0;
        wait_wr_row(3, ok);
        spur = 1;
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = bus.fifo_rd_en;
        end
        if (!ok) check("wait_compute_timeout", 0, 1);
        start = 1'b1; @(posedge clk); #1 start = 1'b0;
        wait_done("run4");
        repeat (20) @(posedge clk);
        #1 check("run4_single_done", done_cnt, 1);

        // spurious readdatavalid in IDLE
        w0 = wr_seen;
        spur = 1;
        repeat (5) @(posedge clk);
        #1 check("idle_spur_no_write", wr_seen - w0, 0);
        check("idle_spur_not_busy", busy, 0);

        // reset during row 5 WAIT
        pulse_start();
        ok = 0;
        for (int i = 0; i < 300 && !ok; i++) begin
            @(negedge clk);
            ok = bus.mem_read && bus.mem_address == 5;
        end
        if (!ok) check("wait_row5_timeout", 0, 1);
        @(posedge clk); #1 rst_n = 1'b0;
        run_active = 0;
        @(posedge clk); #1 rst_n = 1'b1;
        q_en.delete(); q_dat.delete();
        for (int r = 0; r <= ROWS; r++) fq[r].delete();
        @(negedge clk);
        check_quiet("midreset");

        exp_lat = 101;
        pulse_start();
        wait_done("run5");
        check("run5_done_cycle", done_cyc, 101);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
